// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around one shared 8-bit ripple adder.
// Latency: done pulses 8 cycles after the accepted start edge; one product per 9 cycles back-to-back.
// Backpressure: none; start is only accepted in IDLE or DONE and is ignored (not queued) while busy.

// 8-bit ripple-carry adder shared by the multiplier iterations.
module adder8bit (
   input  logic [7:0] X,
   input  logic [7:0] Y,
   input  logic       C0,
   output logic [7:0] sum,
   output logic       C8
);

   logic [8:0] carry;

   // Ripple the carry bit by bit from C0 up to C8.
   always_comb begin
      carry    = 9'd0;
      sum      = 8'd0;
      carry[0] = C0;
      for (int i = 0; i < 8; i++) begin
         sum[i]     = X[i] ^ Y[i] ^ carry[i];
         carry[i+1] = (X[i] & Y[i]) | (X[i] & carry[i]) | (Y[i] & carry[i]);
      end
      C8 = carry[8];
   end

endmodule

module mult8_seq_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic        busy,
   output logic        done,
   output logic [15:0] product
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  m;
   logic [7:0]  p_hi;
   logic [7:0]  q;
   logic [3:0]  cnt;
   logic [7:0]  add_y;
   logic [7:0]  add_sum;
   logic        add_c8;
   logic        accept;
   logic        last_iter;
   logic [15:0] shifted;

   // A new operation can only begin from IDLE or from the single DONE cycle.
   assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
   assign last_iter = (state == S_RUN) && (cnt == 4'd7);

   // Add the multiplicand only when the current multiplier bit is set.
   assign add_y = q[0] ? m : 8'h00;

   adder8bit u_adder (
      .X   (p_hi),
      .Y   (add_y),
      .C0  (1'b0),
      .sum (add_sum),
      .C8  (add_c8)
   );

   // 17-bit right shift of {carry, sum, Q}: the carry lands in P_hi[7], Q[0] falls off.
   assign shifted = {add_c8, add_sum, q[7:1]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: RUN lasts exactly eight iterations, DONE exactly one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_RUN;
         S_RUN:   if (last_iter) state_nxt = S_DONE;
         S_DONE:  state_nxt = accept ? S_RUN : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state, so busy and done are mutually exclusive.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, shift-and-add iteration, and the product register (loaded only entering DONE).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m       <= 8'h00;
         p_hi    <= 8'h00;
         q       <= 8'h00;
         cnt     <= 4'd0;
         product <= 16'h0000;
      end else if (accept) begin
         m    <= A;
         q    <= B;
         p_hi <= 8'h00;
         cnt  <= 4'd0;
      end else if (state == S_RUN) begin
         {p_hi, q} <= shifted;
         cnt       <= cnt + 4'd1;
         if (last_iter) product <= shifted;
      end
   end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl: directed cases plus random operands against a*b.
// Checks cycle timing of busy/done, product hold behaviour, ignored starts and async reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mult8_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int checks = 0;
   int errors = 0;
   logic [15:0] prev_prod;

   mult8_seq_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge with the FSM in IDLE or DONE. Returns at the DONE cycle when
   // keep_start is set, otherwise one cycle later in IDLE.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit keep_start,
                        input int pulse_at, input string tag);
      int nb;
      int nd;
      logic [15:0] exp_prod;
      exp_prod = 16'(a) * 16'(b);
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_prod_hold"}, 32'(product), 32'(prev_prod));
      if (!keep_start) start = 1'b0;
      A = 8'($urandom);
      B = 8'($urandom);
      nb = 0;
      nd = 0;
      for (int c = 1; c <= 8; c++) begin
         if (busy) nb++;
         if (done) nd++;
         if (c == pulse_at) begin
            start = 1'b1;
            A = 8'h03;
            B = 8'h03;
         end else if (pulse_at != 0 && c == pulse_at + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, 32'(nb), 32'd8);
      chk({tag, "_done_early"}, 32'(nd), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_product"}, 32'(product), 32'(exp_prod));
      prev_prod = exp_prod;
      if (!keep_start) begin
         @(negedge clk);
         chk({tag, "_idle_done"}, 32'(done), 32'd0);
         chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
         chk({tag, "_idle_prod"}, 32'(product), 32'(exp_prod));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      A = 8'h00;
      B = 8'h00;
      prev_prod = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);

      do_op(8'h0D, 8'h0B, 1'b0, 0, "d0d_0b");
      do_op(8'hFF, 8'hFF, 1'b0, 0, "ff_ff");
      do_op(8'h00, 8'hA5, 1'b0, 0, "zero_a");
      do_op(8'h5A, 8'h00, 1'b0, 0, "zero_b");
      do_op(8'h10, 8'h10, 1'b0, 4, "ign_start");

      // start held high: second operation accepted in the DONE cycle of the first
      do_op(8'h02, 8'h03, 1'b1, 0, "b2b_first");
      do_op(8'h04, 8'h05, 1'b1, 0, "b2b_second");
      start = 1'b0;
      @(negedge clk);
      chk("b2b_idle_done", 32'(done), 32'd0);
      chk("b2b_idle_busy", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of an operation
      A = 8'h40;
      B = 8'h40;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrun_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_busy", 32'(busy), 32'd0);
      chk("midrun_rst_done", 32'(done), 32'd0);
      chk("midrun_rst_product", 32'(product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after_rst_busy", 32'(busy), 32'd0);
      chk("after_rst_done", 32'(done), 32'd0);
      prev_prod = 16'h0000;
      do_op(8'h07, 8'h09, 1'b0, 0, "post_rst_op");

      // Random operands, randomly back-to-back or with an idle gap
      for (int n = 0; n < 24; n++) begin
         do_op(8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)), 0, "rand");
      end
      start = 1'b0;
      @(negedge clk);
      chk("final_idle_done", 32'(done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
